// File: rtl/matrix_accum_ctrl.sv
// Sequencer that sums MATRICES_COUNT packed matrices through one shared matrix_sum adder.
// Optional adder watchdog and o_error port: define MATRIX_ACCUM_TIMEOUT_EN.
module matrix_accum_ctrl #(
    parameter int unsigned MATRICES_COUNT = 5,
    parameter int unsigned MATRIX_SIZE_M  = 3,
    parameter int unsigned MATRIX_SIZE_N  = 2,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned SIZE_BLOCK    = MATRIX_SIZE_M * MATRIX_SIZE_N * DATA_WIDTH,
    localparam int unsigned CNT_W         = $clog2(MATRICES_COUNT + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    input  logic                  i_matrix_valid,
    output logic                  o_matrix_ready,
    input  logic [SIZE_BLOCK-1:0] i_matrix,
    output logic                  o_sum_calc_cmd,
    output logic [SIZE_BLOCK-1:0] o_sum_matrix_a,
    output logic [SIZE_BLOCK-1:0] o_sum_matrix_b,
    input  logic [SIZE_BLOCK-1:0] i_sum_matrix,
    input  logic                  i_sum_ready,
`ifdef MATRIX_ACCUM_TIMEOUT_EN
    output logic                  o_error,
`endif
    output logic [SIZE_BLOCK-1:0] o_result,
    output logic                  o_done,
    output logic [CNT_W-1:0]      o_count
);

    typedef enum logic [2:0] {StIdle, StLoadFirst, StWaitIn, StAdd, StDone} state_t;

    localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(MATRICES_COUNT);

    state_t                state_q;
    logic [SIZE_BLOCK-1:0] acc_q;
    logic [SIZE_BLOCK-1:0] operand_q;
    logic [SIZE_BLOCK-1:0] result_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_inc;
    logic                  calc_cmd_q;
    logic                  armed_q;

`ifdef MATRIX_ACCUM_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q;
    logic             error_q;
    assign o_error = error_q;
`endif

    // Saturating increment so the count never wraps past MATRICES_COUNT.
    assign count_inc = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            operand_q  <= '0;
            result_q   <= '0;
            count_q    <= '0;
            calc_cmd_q <= 1'b0;
            armed_q    <= 1'b0;
`ifdef MATRIX_ACCUM_TIMEOUT_EN
            tmo_q      <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        count_q <= '0;
                        state_q <= StLoadFirst;
`ifdef MATRIX_ACCUM_TIMEOUT_EN
                        error_q <= 1'b0;
`endif
                    end
                end
                StLoadFirst: begin
                    if (i_matrix_valid) begin
                        acc_q   <= i_matrix;
                        count_q <= CNT_W'(1);
                        if (MATRICES_COUNT == 1) begin
                            result_q <= i_matrix;
                            state_q  <= StDone;
                        end else begin
                            state_q <= StWaitIn;
                        end
                    end
                end
                StWaitIn: begin
                    if (i_matrix_valid) begin
                        operand_q  <= i_matrix;
                        calc_cmd_q <= 1'b1;
                        armed_q    <= 1'b0;
                        state_q    <= StAdd;
`ifdef MATRIX_ACCUM_TIMEOUT_EN
                        tmo_q      <= '0;
`endif
                    end
                end
                StAdd: begin
                    // A ready seen before a low sample may be left over from the previous add.
                    if (i_sum_ready && armed_q) begin
                        acc_q      <= i_sum_matrix;
                        count_q    <= count_inc;
                        calc_cmd_q <= 1'b0;
                        if (count_inc == COUNT_MAX) begin
                            result_q <= i_sum_matrix;
                            state_q  <= StDone;
                        end else begin
                            state_q <= StWaitIn;
                        end
                    end else begin
                        if (!i_sum_ready) begin
                            armed_q <= 1'b1;
                        end
`ifdef MATRIX_ACCUM_TIMEOUT_EN
                        if (tmo_q == TMO_LAST) begin
                            calc_cmd_q <= 1'b0;
                            error_q    <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
`endif
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_busy         = (state_q != StIdle);
    assign o_matrix_ready = (state_q == StLoadFirst) || (state_q == StWaitIn);
    assign o_done         = (state_q == StDone);
    assign o_sum_calc_cmd = calc_cmd_q;
    assign o_sum_matrix_a = acc_q;
    assign o_sum_matrix_b = operand_q;
    assign o_result       = result_q;
    assign o_count        = count_q;

endmodule
